// File: rtl/pipe_ctrl_chain.sv
// rtl/pipe_ctrl_chain.sv - multi-stage control pipeline with per-stage stall/flush (optional stats: PIPE_STATS_EN)
module pipe_ctrl_chain #(
  parameter int              WIDTH   = 8,
  parameter int              DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int              CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [DEPTH-1:0] stall,
  input  logic [DEPTH-1:0] flush,
  output logic [DEPTH-1:0] stage_valid,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             stall_err,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [DEPTH-1:0]            vld;
  logic [DEPTH-1:0][WIDTH-1:0] dat;
  logic                        viol;
  logic                        err_q;

  // A stage that stalls while its valid, unstalled, unflushed upstream neighbour moves
  // would overwrite nothing but silently drop that neighbour's bundle.
  always_comb begin
    viol = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      if (stall[k] && !stall[k-1] && !flush[k-1] && vld[k-1]) begin
        viol = 1'b1;
      end
    end
  end

  // Stage registers: reset > flush > stall > advance, independently per stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dat[k] <= RST_VAL;
      end
    end else begin
      if (flush[0]) begin
        vld[0] <= 1'b0;
        dat[0] <= RST_VAL;
      end else if (!stall[0]) begin
        vld[0] <= in_valid;
        dat[0] <= in_valid ? in_data : RST_VAL;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (flush[k]) begin
          vld[k] <= 1'b0;
          dat[k] <= RST_VAL;
        end else if (!stall[k]) begin
          // A held upstream stage leaves nothing to move forward: insert a bubble.
          if (stall[k-1]) begin
            vld[k] <= 1'b0;
            dat[k] <= RST_VAL;
          end else begin
            vld[k] <= vld[k-1];
            dat[k] <= dat[k-1];
          end
        end
      end
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (viol) begin
      err_q <= 1'b1;
    end
  end

  assign stage_valid = vld;
  assign out_valid   = vld[DEPTH-1];
  assign out_data    = dat[DEPTH-1];
  assign stall_err   = err_q;

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] bubble_q;
  logic [CNT_W-1:0] flush_q;

  // Saturating counters of output bubbles and flush activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (!vld[DEPTH-1] && (bubble_q != {CNT_W{1'b1}})) begin
        bubble_q <= bubble_q + 1'b1;
      end
      if ((|flush) && (flush_q != {CNT_W{1'b1}})) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// tb/tb_pipe_ctrl_chain.sv - self-checking bench for pipe_ctrl_chain
module tb_pipe_ctrl_chain;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [DEPTH-1:0] stall;
  logic [DEPTH-1:0] flush;
  logic [DEPTH-1:0] stage_valid;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             stall_err;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_ctrl_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(8'h00), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .stall(stall), .flush(flush), .stage_valid(stage_valid), .out_valid(out_valid),
    .out_data(out_data), .stall_err(stall_err), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             iv;
    logic [WIDTH-1:0] id;
    logic [DEPTH-1:0] st;
    logic [DEPTH-1:0] fl;
    logic [DEPTH-1:0] esv;
    logic [WIDTH-1:0] eod;
    logic             eerr;
  } vec_t;

  vec_t vecs[$];

  typedef struct {
    logic [WIDTH-1:0] data;
  } sb_t;

  sb_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic iv, input logic [WIDTH-1:0] id,
                     input logic [DEPTH-1:0] st, input logic [DEPTH-1:0] fl,
                     input logic [DEPTH-1:0] esv, input logic [WIDTH-1:0] eod, input logic eerr);
    vec_t v;
    v.rst = r; v.iv = iv; v.id = id; v.st = st; v.fl = fl;
    v.esv = esv; v.eod = eod; v.eerr = eerr;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic iv, input logic [WIDTH-1:0] id,
                       input logic [DEPTH-1:0] st, input logic [DEPTH-1:0] fl);
    reset = r; in_valid = iv; in_data = id; stall = st; flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    logic             v;
    sb_t              e;
    // stream A1..A3, output after 3 edges
    add(0,1,8'hA1,3'b000,3'b000, 3'b001,8'h00,0);
    add(0,1,8'hA2,3'b000,3'b000, 3'b011,8'h00,0);
    add(0,1,8'hA3,3'b000,3'b000, 3'b111,8'hA1,0);
    add(0,0,8'h00,3'b000,3'b000, 3'b110,8'hA2,0);
    add(0,0,8'h00,3'b000,3'b000, 3'b100,8'hA3,0);
    add(0,0,8'h00,3'b000,3'b000, 3'b000,8'h00,0);
    // fill B0..B2, stall 011 one cycle with B3 held upstream
    add(0,1,8'hB0,3'b000,3'b000, 3'b001,8'h00,0);
    add(0,1,8'hB1,3'b000,3'b000, 3'b011,8'h00,0);
    add(0,1,8'hB2,3'b000,3'b000, 3'b111,8'hB0,0);
    add(0,1,8'hB3,3'b011,3'b000, 3'b011,8'h00,0);
    add(0,1,8'hB3,3'b000,3'b000, 3'b111,8'hB1,0);
    add(0,0,8'h00,3'b000,3'b000, 3'b110,8'hB2,0);
    add(0,0,8'h00,3'b000,3'b000, 3'b100,8'hB3,0);
    add(0,0,8'h00,3'b000,3'b000, 3'b000,8'h00,0);
    // stall[1] and flush[1] together: flush wins
    add(0,1,8'hC0,3'b000,3'b000, 3'b001,8'h00,0);
    add(0,1,8'hC1,3'b000,3'b000, 3'b011,8'h00,0);
    add(0,0,8'h00,3'b011,3'b010, 3'b001,8'h00,0);
    add(0,0,8'h00,3'b000,3'b000, 3'b010,8'h00,0);
    add(0,0,8'h00,3'b000,3'b000, 3'b100,8'hC1,0);
    add(0,0,8'h00,3'b000,3'b000, 3'b000,8'h00,0);
    // stall 010 with valid stage 0: sticky error
    add(0,1,8'hE0,3'b000,3'b000, 3'b001,8'h00,0);
    add(0,0,8'h00,3'b010,3'b000, 3'b000,8'h00,1);
    add(0,1,8'hF0,3'b000,3'b000, 3'b001,8'h00,1);
    add(0,1,8'hF1,3'b000,3'b000, 3'b011,8'h00,1);
    add(0,1,8'hF2,3'b000,3'b000, 3'b111,8'hF0,1);
    // reset while full, with stall/flush/in_valid asserted
    add(1,1,8'h55,3'b111,3'b101, 3'b000,8'h00,0);
    // stall 010 with stage 0 empty: not an error
    add(0,0,8'h00,3'b010,3'b000, 3'b000,8'h00,0);
    // flush on the output stage of a moving stream
    add(0,1,8'h11,3'b000,3'b000, 3'b001,8'h00,0);
    add(0,1,8'h22,3'b000,3'b000, 3'b011,8'h00,0);
    add(0,1,8'h33,3'b000,3'b000, 3'b111,8'h11,0);
    add(0,0,8'h00,3'b000,3'b100, 3'b010,8'h00,0);
    add(0,0,8'h00,3'b000,3'b000, 3'b100,8'h33,0);
    add(0,0,8'h00,3'b000,3'b000, 3'b000,8'h00,0);

    // reset state
    drive(1, 0, 8'h00, 3'b000, 3'b000);
    chk("rst_stage_valid", 32'(stage_valid), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_stall_err", 32'(stall_err), 32'h0);
    chk("rst_bubble_cnt", 32'(bubble_cnt), 32'h0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].id, vecs[i].st, vecs[i].fl);
      chk($sformatf("v%0d_stage_valid", i), 32'(stage_valid), 32'(vecs[i].esv));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].esv[DEPTH-1]));
      chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].eod));
      chk($sformatf("v%0d_stall_err", i), 32'(stall_err), 32'(vecs[i].eerr));
    end

    // counters: 5 idle cycles then one flush cycle
    drive(1, 0, 8'h00, 3'b000, 3'b000);
    for (int i = 0; i < 5; i++) drive(0, 0, 8'h00, 3'b000, 3'b000);
`ifdef PIPE_STATS_EN
    chk("bubble_sat", 32'(bubble_cnt), 32'h3);
`else
    chk("bubble_off", 32'(bubble_cnt), 32'h0);
`endif
    drive(0, 0, 8'h00, 3'b000, 3'b010);
`ifdef PIPE_STATS_EN
    chk("flush_cnt_one", 32'(flush_cnt), 32'h1);
`else
    chk("flush_off", 32'(flush_cnt), 32'h0);
`endif
    drive(1, 0, 8'h00, 3'b000, 3'b000);
    chk("cnt_reset_bubble", 32'(bubble_cnt), 32'h0);
    chk("cnt_reset_flush", 32'(flush_cnt), 32'h0);

    // random stream, no stall: scoreboard of valid bundles in order
    for (int i = 0; i < 40 + DEPTH; i++) begin
      if (i < 40) begin
        v = 1'($urandom_range(0, 1));
        d = 8'($urandom_range(1, 255));
      end else begin
        v = 1'b0;
        d = 8'h00;
      end
      if (v) begin
        e.data = d;
        sb.push_back(e);
      end
      drive(0, v, d, 3'b000, 3'b000);
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("sb_out_data", 32'(out_data), 32'(e.data));
        end
      end else begin
        chk("sb_bubble_data", 32'(out_data), 32'h0);
      end
    end
    chk("sb_drained", 32'(sb.size()), 32'h0);
    chk("sb_no_err", 32'(stall_err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
